// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable synchronous down counter with terminal-count pulse
//
// Countdown timer. LOAD_VAL is loaded into both the counter and a reload
// register, and the counter then decrements while EN is high. A one-cycle TC
// pulse marks the cycle in which Out first reads zero. In one-shot mode
// (MODE=0) the counter stops there. In auto-reload mode (MODE=1) the counter
// restarts from the reload value on the next enabled edge.
//
// Ports:
//   CLK       clock; every state change happens on its rising edge
//   RST_N     asynchronous active-low reset
//   LOAD      load LOAD_VAL into the counter and the reload register; overrides EN
//   LOAD_VAL  start/reload value (WIDTH bits)
//   EN        count enable; when low, all state holds
//   MODE      0 = one-shot, 1 = auto-reload
//   Out       current count, registered
//   TC        terminal-count pulse, registered, one cycle wide
//   ZERO      combinational, Out == 0
//   BUSY      high while counting (RUN state)

module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             EN,
    input  logic             MODE,
    output logic [WIDTH-1:0] Out,
    output logic             TC,
    output logic             ZERO,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // Borrow chain: bit i toggles when every lower bit is zero. This mirrors
    // the carry chain of the up counter. The result is only used when the
    // counter is nonzero, so it never wraps.
    logic [WIDTH-1:0] dec_val;
    logic             borrow;

    always_comb begin
        dec_val = '0;
        borrow  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            dec_val[i] = cnt_q[i] ^ borrow;
            borrow     = borrow & ~cnt_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (LOAD) begin
            cnt_d    = LOAD_VAL;
            reload_d = LOAD_VAL;
            // Loading zero skips straight to DONE, so it never produces a TC.
            state_d  = (LOAD_VAL != '0) ? RUN : DONE;
        end else begin
            case (state_q)
                RUN: begin
                    if (EN) begin
                        if (cnt_q != '0) begin
                            cnt_d = dec_val;
                            if (cnt_q == WIDTH'(1)) begin
                                tc_d = 1'b1;
                                if (!MODE) begin
                                    state_d = DONE;
                                end
                            end
                        end else if (MODE) begin
                            cnt_d = reload_q;
                        end else begin
                            // MODE dropped to 0 while the counter rested at zero
                            // in auto-reload mode; the count finishes here.
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold everything; only LOAD leaves them.
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign Out  = cnt_q;
    assign TC   = tc_q;
    assign ZERO = (cnt_q == '0);
    assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - self-checking bench for sync_down_counter

module tb_sync_down_counter;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b1;
    logic             LOAD = 1'b0;
    logic [WIDTH-1:0] LOAD_VAL = '0;
    logic             EN = 1'b0;
    logic             MODE = 1'b0;
    logic [WIDTH-1:0] Out;
    logic             TC;
    logic             ZERO;
    logic             BUSY;

    int checks = 0;
    int errors = 0;

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .EN       (EN),
        .MODE     (MODE),
        .Out      (Out),
        .TC       (TC),
        .ZERO     (ZERO),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string            name;
        logic             load;
        logic [WIDTH-1:0] lv;
        logic             en;
        logic             mode;
        logic [WIDTH-1:0] out;
        logic             tc;
        logic             busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic load, logic [WIDTH-1:0] lv, logic en,
                                logic mode, logic [WIDTH-1:0] out, logic tc, logic busy);
        vec_t v;
        v.name = name; v.load = load; v.lv = lv; v.en = en; v.mode = mode;
        v.out = out; v.tc = tc; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] exp_out,
                         input logic exp_tc, input logic exp_busy);
        logic exp_zero;
        exp_zero = (exp_out == '0);
        checks++;
        if (Out !== exp_out || TC !== exp_tc || BUSY !== exp_busy || ZERO !== exp_zero) begin
            errors++;
            $display("FAIL %s: got Out=%0d TC=%0b BUSY=%0b ZERO=%0b, expected Out=%0d TC=%0b BUSY=%0b ZERO=%0b",
                     name, Out, TC, BUSY, ZERO, exp_out, exp_tc, exp_busy, exp_zero);
        end
    endtask

    task automatic step(input logic load, input logic [WIDTH-1:0] lv, input logic en,
                        input logic mode);
        LOAD = load; LOAD_VAL = lv; EN = en; MODE = mode;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle after reset: EN alone does nothing.
        vecs.push_back(mk("idle_en",   0, 0, 1, 0, 0, 0, 0));
        // One-shot from 5.
        vecs.push_back(mk("os_load",   1, 5, 0, 0, 5, 0, 1));
        vecs.push_back(mk("os_4",      0, 0, 1, 0, 4, 0, 1));
        vecs.push_back(mk("os_3",      0, 0, 1, 0, 3, 0, 1));
        vecs.push_back(mk("os_2",      0, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk("os_1",      0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("os_0_tc",   0, 0, 1, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk("os_hold",   0, 0, 1, 0, 0, 0, 0));
        // Auto-reload from 3.
        vecs.push_back(mk("ar_load",   1, 3, 1, 1, 3, 0, 1));
        vecs.push_back(mk("ar_2",      0, 0, 1, 1, 2, 0, 1));
        vecs.push_back(mk("ar_1",      0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("ar_0_tc",   0, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk("ar_rel3",   0, 0, 1, 1, 3, 0, 1));
        vecs.push_back(mk("ar_2b",     0, 0, 1, 1, 2, 0, 1));
        vecs.push_back(mk("ar_1b",     0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("ar_0b_tc",  0, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk("ar_rel3b",  0, 0, 1, 1, 3, 0, 1));
        // EN gating at Out=2.
        vecs.push_back(mk("en_2",      0, 0, 1, 1, 2, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("en_hold",   0, 0, 0, 1, 2, 0, 1));
        vecs.push_back(mk("en_1",      0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("en_0_tc",   0, 0, 1, 1, 0, 1, 1));
        // LOAD wins over the final decrement.
        vecs.push_back(mk("lp_load2",  1, 2, 0, 0, 2, 0, 1));
        vecs.push_back(mk("lp_1",      0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("lp_load9",  1, 9, 1, 0, 9, 0, 1));
        // Loading zero: DONE, no TC.
        vecs.push_back(mk("lz_load0",  1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("lz_hold",   0, 0, 1, 1, 0, 0, 0));
        // MODE 1->0 mid-run makes this the last pass.
        vecs.push_back(mk("ms_load4",  1, 4, 0, 1, 4, 0, 1));
        vecs.push_back(mk("ms_3",      0, 0, 1, 1, 3, 0, 1));
        vecs.push_back(mk("ms_2",      0, 0, 1, 1, 2, 0, 1));
        vecs.push_back(mk("ms_1",      0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("ms_0_tc",   0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("ms_noreld", 0, 0, 1, 1, 0, 0, 0));

        // Asynchronous reset with no clock edge.
        #2 RST_N = 1'b0;
        #1 check("reset_async", 0, 0, 0);
        @(posedge CLK);
        #1 check("reset_held", 0, 0, 0);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].mode);
            check(vecs[i].name, vecs[i].out, vecs[i].tc, vecs[i].busy);
        end

        // Full-range auto-reload: LOAD 15 gives a 16-cycle period.
        step(1, 15, 0, 1);
        check("fr_load", 15, 0, 1);
        for (int k = 1; k <= 32; k++) begin
            logic [WIDTH-1:0] e;
            e = (k % 16 == 0) ? 4'd15 : 4'(15 - (k % 16));
            step(0, 0, 1, 1);
            check("fr_cycle", e, (e == 0), 1);
        end

        // Reset mid-count at Out=6 aborts the count; no TC afterwards.
        step(1, 8, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("rm_at6", 6, 0, 1);
        #2 RST_N = 1'b0;
        #1 check("rm_async", 0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        step(0, 0, 1, 0);
        check("rm_idle", 0, 0, 0);
        step(0, 0, 1, 1);
        check("rm_idle2", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
